crc32_feeder: RTL
=================

# crc32_feeder

Byte-sequencing controller between the TinyQV register interface and the `crc32_v` byte engine. Software pushes message words (1–4 valid bytes each) into a small FIFO. The feeder splits each word into bytes, LSB first, and drives them into the engine one at a time using the engine's trigger/done handshake. At end of message it latches the final CRC before releasing the engine to IDLE, because IDLE reinitialises the engine's CRC register. The feeder also supports abort and reports progress and status.

## Interface
- `FIFO_DEPTH`, default 4: word FIFO depth; power of two, minimum 2.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `wr_valid`  in  1  push request for one message word.
- `wr_ready`  out  1  FIFO can accept a word; low when full or when `abort`=1.
- `wr_data`  in  32  message word; byte 0 is `[7:0]`.
- `wr_nbytes`  in  2  number of valid bytes minus 1 (0 means 1 byte, 3 means 4 bytes).
- `wr_last`  in  1  this word ends the message.
- `abort`  in  1  single-cycle abort of the current message.
- `crc_trigger`  out  1  to engine `crc_trigger`.
- `crc_byte`  out  8  to engine `crc_32_in`.
- `crc_data_done`  out  1  to engine `data_done`.
- `crc_busy`  in  1  from engine `crc_busy`.
- `crc_done_pulse`  in  1  from engine `done_pulse`.
- `crc_value`  in  32  from engine `crc_out32_xor`.
- `result`  out  32  latched final CRC.
- `result_valid`  out  1  `result` holds a completed message's CRC.
- `msg_active`  out  1  a message is in progress.
- `msg_done`  out  1  one-cycle pulse on message completion.
- `aborted`  out  1  sticky; the last message was aborted.
- `byte_count`  out  16  bytes fed in the current/last message; wraps modulo 2^16.
- `fifo_level`  out  clog2(FIFO_DEPTH)+1  occupied FIFO entries.

## Operation
- FIFO entry format: {last, nbytes, data}.
    - Push when `wr_valid & wr_ready`.
    - No bypass: a pushed word is visible in FIFO state the following cycle.
    - A push and a pop in the same cycle are both allowed; the level is unchanged.
- States:
    - IDLE: engine idle or parked in Done; if FIFO is non-empty, go to LOAD.
    - LOAD: pop the head word into the working register; byte index = 0; go to ISSUE.
    - ISSUE: `crc_byte` = working byte[index]. When `crc_busy`=0, assert `crc_trigger` for exactly that cycle and go to WAIT; otherwise stay.
    - WAIT: hold `crc_byte` stable. On `crc_done_pulse`, increment `byte_count`, then:
        - if index < nbytes, increment index and go to ISSUE;
        - else if the word's last bit is set, go to FINISH;
        - else if FIFO is non-empty, go to LOAD;
        - else go to IDLE with `msg_active` kept at 1.
    - FINISH (one cycle): `result` <= `crc_value`; `crc_data_done`=1; `msg_done`=1; `result_valid` <= 1; `msg_active` <= 0; go to IDLE.
    - DRAIN: wait for `crc_done_pulse` of the outstanding byte, then assert `crc_data_done` for one cycle, `aborted` <= 1, `msg_active` <= 0, go to IDLE. `result` is not updated and `msg_done` stays 0.
- First trigger of a message:
    - clears `result_valid` and `aborted`;
    - loads `byte_count` = 0, reaching 1 at that byte's done pulse;
    - sets `msg_active`.
- Abort handling:
    - `abort` flushes the FIFO in the same cycle; a simultaneous write is dropped.
    - From WAIT, or from ISSUE in the trigger cycle: go to DRAIN.
    - From ISSUE with no trigger issued, or from LOAD: pulse `crc_data_done`, set `aborted`, go to IDLE.
    - From IDLE with `msg_active`=1: same as the previous case.
    - From IDLE with `msg_active`=0: flush only.
- `crc_byte` is the only engine input the feeder drives with data. Engine configuration pins (RefIn/RefOut/Xor_out/Init/POLY_in) come from the register file, and software must not change them while `msg_active`=1.
- Zero-length messages are not representable; every word carries at least 1 byte.

## Timing
- Reset (`rst_n`=0 at an edge) clears everything regardless of state, including mid-message:
    - all outputs 0 and `result` = 0;
    - FIFO empty, state IDLE.
    - The engine shares the same reset.
- Word pushed at cycle 0 into an empty feeder in IDLE:
    - LOAD at cycle 2;
    - `crc_trigger` at cycle 3;
    - engine: Byte_Xor at cycle 4, Poly_Xor at cycles 5–12, Done at cycle 13;
    - `crc_done_pulse` at cycle 14.
    - The next byte triggers at cycle 15 (12 cycles per byte steady state).
    - For a last byte, FINISH is at cycle 15 and `result_valid`=1 from cycle 16.
- Word boundaries add one LOAD cycle per word.
- The engine sits in Done at FINISH, so `crc_value` is sampled while still valid. The engine enters IDLE at the following edge.
- A new message may LOAD the cycle after FINISH.
- `crc_trigger`, `crc_data_done` and `msg_done` are never high for more than one consecutive cycle.

## Test plan
- Engine set to CRC-32 (RefIn=1, RefOut=1, Xor_out=1, Init=1, POLY 0x04C11DB7); push 0x00000031, nbytes=0, last=1 at cycle 0 -> trigger at cycle 3, `msg_done` at cycle 15, `result`=0x83DCEFB7, `byte_count`=1.
- Same engine configuration; push 0x34333231 (nbytes=3), 0x38373635 (nbytes=3), 0x00000039 (nbytes=0, last) back-to-back -> 9 triggers, `result`=0xCBF43926, `byte_count`=9.
- FIFO_DEPTH=4; 6 non-last words pushed continuously -> `wr_ready` drops at level 4, no word lost or duplicated, byte order LSB first on `crc_byte`.
- `abort` while in WAIT on byte 2 of a message -> DRAIN until the done pulse, one `crc_data_done`, `aborted`=1, previous `result` unchanged, `msg_done` never asserted.
- `rst_n` low mid-message for one cycle -> all outputs 0 next cycle; a fresh "1" message then gives 0x83DCEFB7.
- Two messages back-to-back -> second message's first trigger no earlier than 2 cycles after the first message's FINISH; `result_valid` falls on that trigger.

Source files
------------

// File: rtl/crc32_feeder.sv
// crc32_feeder: queues message words from the register interface and feeds
// them byte by byte (LSB first) into the crc32_v engine, latching the final
// CRC before the engine is released back to IDLE.
module crc32_feeder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            wr_valid,
   output logic                            wr_ready,
   input  logic [31:0]                     wr_data,
   input  logic [1:0]                      wr_nbytes,
   input  logic                            wr_last,
   input  logic                            abort,
   output logic                            crc_trigger,
   output logic [7:0]                      crc_byte,
   output logic                            crc_data_done,
   input  logic                            crc_busy,
   input  logic                            crc_done_pulse,
   input  logic [31:0]                     crc_value,
   output logic [31:0]                     result,
   output logic                            result_valid,
   output logic                            msg_active,
   output logic                            msg_done,
   output logic                            aborted,
   output logic [15:0]                     byte_count,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_FINISH,
      S_DRAIN
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [34:0]     fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            fifo_empty;
   logic            fifo_full;
   logic            push;
   logic            pop;
   logic [34:0]     head;

   logic [31:0]     work_data;
   logic [1:0]      work_nbytes;
   logic            work_last;
   logic [1:0]      byte_idx;

   logic            load_work;
   logic            inc_idx;
   logic            inc_count;
   logic            first_trig;
   logic            latch_result;
   logic            end_msg;
   logic            set_aborted;

   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
   assign wr_ready   = !fifo_full && !abort;
   assign push       = wr_valid && wr_ready;
   assign head       = fifo_mem[rd_ptr];

   // FIFO storage: entry is {last, nbytes, data}; contents need no reset
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {wr_last, wr_nbytes, wr_data};
      end
   end

   // FIFO pointers and level; abort empties the queue immediately
   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Working word register, loaded from the FIFO head in LOAD
   always_ff @(posedge clk) begin
      if (load_work) begin
         {work_last, work_nbytes, work_data} <= head;
      end
   end

   // Byte currently offered to the engine; held through WAIT and DRAIN
   always_comb begin
      crc_byte = '0;
      if (state == S_ISSUE || state == S_WAIT || state == S_DRAIN) begin
         crc_byte = work_data[8*byte_idx +: 8];
      end
   end

   // State register, byte index and message status
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         byte_idx     <= '0;
         byte_count   <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         msg_active   <= 1'b0;
         aborted      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_work) begin
            byte_idx <= '0;
         end else if (inc_idx) begin
            byte_idx <= byte_idx + 2'd1;
         end
         if (first_trig) begin
            byte_count   <= '0;
            result_valid <= 1'b0;
            aborted      <= 1'b0;
            msg_active   <= 1'b1;
         end
         if (inc_count) begin
            byte_count <= byte_count + 16'd1;
         end
         if (latch_result) begin
            result       <= crc_value;
            result_valid <= 1'b1;
         end
         if (end_msg) begin
            msg_active <= 1'b0;
         end
         if (set_aborted) begin
            aborted <= 1'b1;
         end
      end
   end

   // Next-state logic and engine handshake strobes
   always_comb begin
      state_nxt     = state;
      crc_trigger   = 1'b0;
      crc_data_done = 1'b0;
      msg_done      = 1'b0;
      pop           = 1'b0;
      load_work     = 1'b0;
      inc_idx       = 1'b0;
      inc_count     = 1'b0;
      first_trig    = 1'b0;
      latch_result  = 1'b0;
      end_msg       = 1'b0;
      set_aborted   = 1'b0;
      case (state)
         S_IDLE: begin
            if (abort) begin
               // Engine is parked in Done if a message is open; release it
               if (msg_active) begin
                  crc_data_done = 1'b1;
                  set_aborted   = 1'b1;
                  end_msg       = 1'b1;
               end
            end else if (!fifo_empty) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               crc_data_done = 1'b1;
               set_aborted   = 1'b1;
               end_msg       = 1'b1;
               state_nxt     = S_IDLE;
            end else begin
               pop       = 1'b1;
               load_work = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!crc_busy) begin
               crc_trigger = 1'b1;
               first_trig  = !msg_active;
               // A byte launched this cycle must finish before release
               state_nxt   = abort ? S_DRAIN : S_WAIT;
            end else if (abort) begin
               crc_data_done = 1'b1;
               set_aborted   = 1'b1;
               end_msg       = 1'b1;
               state_nxt     = S_IDLE;
            end
         end
         S_WAIT: begin
            if (crc_done_pulse) begin
               inc_count = 1'b1;
               if (abort) begin
                  // Outstanding byte already completed; no drain needed
                  crc_data_done = 1'b1;
                  set_aborted   = 1'b1;
                  end_msg       = 1'b1;
                  state_nxt     = S_IDLE;
               end else if (byte_idx < work_nbytes) begin
                  inc_idx   = 1'b1;
                  state_nxt = S_ISSUE;
               end else if (work_last) begin
                  state_nxt = S_FINISH;
               end else if (!fifo_empty) begin
                  state_nxt = S_LOAD;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else if (abort) begin
               state_nxt = S_DRAIN;
            end
         end
         S_FINISH: begin
            // Engine still in Done: crc_value is the final CRC this cycle
            latch_result  = 1'b1;
            crc_data_done = 1'b1;
            msg_done      = 1'b1;
            end_msg       = 1'b1;
            state_nxt     = (!abort && !fifo_empty) ? S_LOAD : S_IDLE;
         end
         S_DRAIN: begin
            if (crc_done_pulse) begin
               inc_count     = 1'b1;
               crc_data_done = 1'b1;
               set_aborted   = 1'b1;
               end_msg       = 1'b1;
               state_nxt     = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
